// File: rtl/cplx_operand_fetch_pkg.sv
// Shared types and helpers for the complex operand fetch sequencer:
// FSM state encoding, complex word layout constants and conjugation.
package cplx_fetch_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fetch_state_t;

  localparam int CPLX_W        = 48;
  localparam int HALF_W        = 24;
  localparam int IMAG_SIGN_BIT = 23;

  // Conjugate of a packed {real, imag} FP word: flip only the imaginary sign.
  function automatic logic [CPLX_W-1:0] cplx_conj(input logic [CPLX_W-1:0] w);
    return {w[CPLX_W-1:HALF_W], ~w[IMAG_SIGN_BIT], w[IMAG_SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/cplx_operand_fetch_valid_delay_line.sv
// Fixed-depth shift register carrying {valid, last} flags alongside the
// read/multiply pipeline; clearing it on reset discards in-flight products.
module valid_delay_line
  import cplx_fetch_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [1:0] stage [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= 2'b00;
    end else begin
      stage[0] <= {in_valid, in_last};
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_valid = stage[DEPTH-1][1];
  assign out_last  = stage[DEPTH-1][0];

endmodule

// File: rtl/cplx_operand_fetch.sv
// Walks row ROW of Y and column COL of V through two read SRAMs and feeds
// the complex multiplier operands. Optional macro: CPLX_FETCH_CONJ_EN.
module cplx_operand_fetch
  import cplx_fetch_pkg::*;
#(
  parameter int DATA_W   = CPLX_W,
  parameter int DIM      = 8,
  parameter int LOG_DIM  = 3,
  parameter int ADDR_W   = 6,
  parameter int RD_LAT   = 1,
  parameter int MULT_LAT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LOG_DIM-1:0] row_idx,
  input  logic [LOG_DIM-1:0] col_idx,
`ifdef CPLX_FETCH_CONJ_EN
  input  logic              conj,
`endif
  output logic              busy,
  output logic [ADDR_W-1:0] y_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] y_rdata,
  input  logic [DATA_W-1:0] v_rdata,
  output logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] in2,
  output logic              prod_valid,
  output logic              prod_last,
  output logic              done
);

  localparam int PIPE_DEPTH = RD_LAT + 1 + MULT_LAT;
  localparam logic [LOG_DIM-1:0] K_LAST = LOG_DIM'(DIM - 1);

  fetch_state_t state, next_state;
  logic [LOG_DIM-1:0] row_q, col_q, k_q;
  logic rd_pipe [RD_LAT];
  logic accept, issue_last, capture;

  assign accept     = (state == IDLE) && start;
  assign issue_last = (state == ISSUE) && (k_q == K_LAST);
  assign capture    = rd_pipe[RD_LAT-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)           next_state = ISSUE;
      ISSUE:   if (k_q == K_LAST)   next_state = DRAIN;
      DRAIN:   if (prod_last)       next_state = DONE;
      DONE:                         next_state = IDLE;
      default:                      next_state = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    rd_en = (state == ISSUE);
    done  = (state == DONE);
  end

  // k saturates at DIM-1 so the addresses hold their last value through DRAIN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
      k_q   <= '0;
    end else if (accept) begin
      row_q <= row_idx;
      col_q <= col_idx;
      k_q   <= '0;
    end else if (state == ISSUE && k_q != K_LAST) begin
      k_q <= k_q + 1'b1;
    end
  end

  assign y_addr = {row_q, k_q};
  assign v_addr = {k_q, col_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= 1'b0;
    end else begin
      rd_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

`ifdef CPLX_FETCH_CONJ_EN
  logic conj_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    conj_q <= 1'b0;
    else if (accept) conj_q <= conj;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in1 <= '0;
      in2 <= '0;
    end else if (capture) begin
      in1 <= y_rdata;
`ifdef CPLX_FETCH_CONJ_EN
      in2 <= conj_q ? cplx_conj(v_rdata) : v_rdata;
`else
      in2 <= v_rdata;
`endif
    end
  end

  valid_delay_line #(
    .DEPTH(PIPE_DEPTH)
  ) u_valid_delay (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (rd_en),
    .in_last  (issue_last),
    .out_valid(prod_valid),
    .out_last (prod_last)
  );

endmodule

// File: doc/cplx_operand_fetch.md
Name: cplx_operand_fetch

Overview:
- Upstream sequencer for the complex FP multiplier stage in the Y/V SRAM datapath.
- On start, it walks row ROW of the Y matrix and column COL of the V matrix, one element per cycle, through two single-port read SRAMs.
- It registers each element pair into the multiplier's in1/in2 operands.
- It tracks pipeline latency so that product valid/last flags align with the multiplier's output op.

Parameters:
- DATA_W, 48: complex word width; real in [47:24], imag in [23:0] (24-bit FP each).
- DIM, 8: matrix dimension; power of 2, range 2..64.
- LOG_DIM, 3: log2(DIM).
- ADDR_W, 6: SRAM address width; equals 2*LOG_DIM.
- RD_LAT, 1: SRAM read latency in cycles (1..3).
- MULT_LAT, 4: cycles from in1/in2 register update to valid op at the multiplier output.

Ports:
- clock, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle request to begin a fetch; accepted only when idle.
- row_idx, in, LOG_DIM: Y row, captured at start.
- col_idx, in, LOG_DIM: V column, captured at start.
- busy, out, 1: high from accepted start through done.
- y_addr, out, ADDR_W: Y SRAM address.
- v_addr, out, ADDR_W: V SRAM address.
- rd_en, out, 1: read enable to both SRAMs.
- y_rdata, in, DATA_W: Y read data; valid RD_LAT cycles after rd_en.
- v_rdata, in, DATA_W: V read data; valid RD_LAT cycles after rd_en.
- in1, out, DATA_W: registered multiplier operand (Y element).
- in2, out, DATA_W: registered multiplier operand (V element).
- prod_valid, out, 1: high in cycles where the multiplier op holds a valid product.
- prod_last, out, 1: qualifies the final (k=DIM-1) product.
- done, out, 1: one-cycle pulse the cycle after prod_last.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, delay lines cleared.
- FSM states and transitions:
  - IDLE: start=1 captures row_idx/col_idx, clears k, sets busy -> ISSUE. start=0 stays in IDLE.
  - ISSUE: rd_en=1, y_addr = row*DIM + k, v_addr = k*DIM + col; k increments each cycle. After the cycle with k=DIM-1 -> DRAIN. Exactly DIM consecutive reads, no gaps.
  - DRAIN: rd_en=0, addresses hold their last value. Wait for the last product to emerge; on prod_last -> DONE.
  - DONE: done=1 for one cycle, busy drops next cycle -> IDLE.
- Operand capture: SRAM data returning at issue+RD_LAT is registered into in1/in2 on that edge, so operands are valid at issue+RD_LAT+1.
- in1/in2 hold their last value when no new data returns.
- Valid tracking: a shift register of depth RD_LAT+1+MULT_LAT carries (valid, last).
  - prod_valid for element k is asserted exactly RD_LAT+1+MULT_LAT cycles after the cycle that issued k.
  - prod_last rides with k=DIM-1.
- Total latency: start-accept cycle T0, first issue at T0+1, last prod_valid at T0+DIM+RD_LAT+1+MULT_LAT, done one cycle later.
- No backpressure: the multiplier pipeline cannot stall, so the downstream consumer must accept every prod_valid.
- Boundary and corner cases:
  - start while busy: ignored, no effect on the current fetch.
  - start in the same cycle as done: ignored; the new start must arrive after busy=0.
  - row_idx/col_idx changing during busy: no effect.
  - Address arithmetic is concatenation ({row,k} and {k,col}); never exceeds DIM*DIM-1, no wrap.
  - reset_n low at any time: immediately clears FSM, rd_en, busy, and all valid/last bits. No spurious prod_valid or done after reset release. Products already inside the multiplier are discarded because their flags are cleared.

Optional Feature:
- Macro: CPLX_FETCH_CONJ_EN.
- Defined: adds input conj (1 bit), captured at start.
  - When captured high, in2 is loaded with the conjugate of v_rdata: bit 23 (imag sign) inverted, all other bits passed through. This supports V^H products.
- Undefined: no conj port; in2 = v_rdata exactly.

Decomposition:
- Package cplx_fetch_pkg:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - constants CPLX_W=48, HALF_W=24, IMAG_SIGN_BIT=23;
  - a helper function for conjugation.
- One sub-module is natural: valid_delay_line, a parameterised-depth shift register carrying {valid, last}, with asynchronous active-low reset.

Test Plan:
- Basic walk (DIM=8, row=2, col=5, RD_LAT=1, MULT_LAT=4, start at T0):
  - y_addr 16..23 and v_addr 5,13,21,...,61 issued at T0+1..T0+8.
  - prod_valid high T0+7..T0+14; prod_last at T0+14; done at T0+15; busy low at T0+16.
- Corner indices (row=7, col=7): y_addr 56..63, v_addr 7,15,...,63; no out-of-range address.
- Operand alignment: SRAM model returns y=48'h3C0000_000000 and v=48'h400000_000000 for k=3 -> in1/in2 show those values at issue(k=3)+2.
- Start while busy: second start pulse at T0+4 -> ignored; exactly 8 prod_valid pulses, one done.
- Reset mid-operation: reset_n low at T0+5 for 2 cycles -> all outputs 0 immediately; no prod_valid/done afterwards. A fresh start after reset completes normally.
- CPLX_FETCH_CONJ_EN with conj=1: v_rdata=48'h3C0000_3C0000 -> in2=48'h3C0000_BC0000. With conj=0, in2 is unchanged.
